// File: rtl/fb_scanout_arbiter_if.sv
// SRAM and host-write bus bundle for the framebuffer scanout arbiter.
// The slave modport is the arbiter's view; master is the SRAM/host side.
interface fb_scanout_arbiter_if #(
  parameter int W_ADDR = 18
);
  logic [W_ADDR-1:0] mem_addr;
  logic              mem_ren;
  logic              mem_wen;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic [W_ADDR-1:0] host_addr;
  logic [15:0]       host_wdata;
  logic              host_valid;
  logic              host_ready;

  modport slave (
    output mem_addr, mem_ren, mem_wen, mem_wdata, host_ready,
    input  mem_rdata, host_addr, host_wdata, host_valid
  );

  modport master (
    input  mem_addr, mem_ren, mem_wen, mem_wdata, host_ready,
    output mem_rdata, host_addr, host_wdata, host_valid
  );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// Shares one single-port framebuffer SRAM between display scanout (a small
// pixel FIFO kept topped up by sequential reads) and a host write port.
module fb_scanout_arbiter #(
  parameter int H_PIX      = 320,
  parameter int V_PIX      = 480,
  parameter int W_ADDR     = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk_pix,
  input  logic                rst_n_pix,
  input  logic                en,
  fb_scanout_arbiter_if.slave bus,
  input  logic                rgb_rdy,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  output logic                frame_start,
  output logic                underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [W_ADDR-1:0] LAST_PIX = W_ADDR'(H_PIX * V_PIX - 1);
  localparam logic [PW+1:0]     HALF     = (PW+2)'(FIFO_DEPTH / 2);
  localparam logic [PW+1:0]     FULL     = (PW+2)'(FIFO_DEPTH);

  logic [15:0]       fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [W_ADDR-1:0] rd_cnt_q, rd_cnt_d, pop_cnt_q, pop_cnt_d;
  logic              infl_q, infl_d, kill_q, kill_d;
  logic              resync_q, resync_d, uf_q, uf_d;

  logic [PW+1:0] credits;
  logic          empty, urgent, rd_gnt, wr_gnt;
  logic          pop, push, uf_evt, wrap, flush;
  logic [15:0]   head;
  logic          show;

  // An outstanding read already owns a FIFO slot, so it counts as a credit.
  assign credits = (PW+2)'(cnt_q) + (PW+2)'(infl_q);
  assign empty   = (cnt_q == '0);
  assign urgent  = en && (credits < HALF);

  assign pop    = en && rgb_rdy && !empty;
  assign uf_evt = en && rgb_rdy && empty;
  assign wrap   = en && rgb_rdy && (pop_cnt_q == LAST_PIX);
  assign flush  = !en || (resync_q && wrap);
  // A read returning in a flush cycle, or issued in one, is dropped.
  assign push   = infl_q && !kill_q && !flush;

  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (rst_n_pix) begin
      if (urgent)                          rd_gnt = 1'b1;
      else if (bus.host_valid)             wr_gnt = 1'b1;
      else if (en && (credits < FULL))     rd_gnt = 1'b1;
    end
  end

  assign bus.mem_ren    = rd_gnt;
  assign bus.mem_wen    = wr_gnt;
  assign bus.host_ready = wr_gnt;
  assign bus.mem_addr   = rd_gnt ? rd_cnt_q : (wr_gnt ? bus.host_addr : '0);
  assign bus.mem_wdata  = wr_gnt ? bus.host_wdata : '0;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    pop_cnt_d = pop_cnt_q;
    infl_d    = rd_gnt;
    kill_d    = rd_gnt && flush;
    resync_d  = resync_q;
    uf_d      = uf_q | uf_evt;

    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PW'(1);
      if (pop)  rp_d = rp_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    if (flush)       rd_cnt_d = '0;
    else if (rd_gnt) rd_cnt_d = (rd_cnt_q == LAST_PIX) ? '0 : rd_cnt_q + W_ADDR'(1);

    if (!en)         pop_cnt_d = '0;
    else if (rgb_rdy) pop_cnt_d = wrap ? '0 : pop_cnt_q + W_ADDR'(1);

    if (resync_q && wrap) resync_d = 1'b0;
    else if (uf_evt)      resync_d = 1'b1;
  end

  always_ff @(posedge clk_pix or negedge rst_n_pix) begin
    if (!rst_n_pix) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_cnt_q  <= '0;
      pop_cnt_q <= '0;
      infl_q    <= 1'b0;
      kill_q    <= 1'b0;
      resync_q  <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      pop_cnt_q <= pop_cnt_d;
      infl_q    <= infl_d;
      kill_q    <= kill_d;
      resync_q  <= resync_d;
      uf_q      <= uf_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (push) fifo_q[wp_q] <= bus.mem_rdata;
  end

  // RGB565 -> RGB888 by replicating the top bits into the low bits.
  assign head        = fifo_q[rp_q];
  assign show        = en && !empty;
  assign r           = show ? {head[15:11], head[15:13]} : '0;
  assign g           = show ? {head[10:5],  head[10:9]}  : '0;
  assign b           = show ? {head[4:0],   head[4:2]}   : '0;
  assign frame_start = rst_n_pix && en && rgb_rdy && (pop_cnt_q == '0);
  assign underflow   = uf_q;
endmodule
